// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: operand/result valid-ready bundle for addsub_pipe.
interface addsub_pipe_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
);
  logic [WIDTH-1:0]     sig_as_ina;
  logic [WIDTH-1:0]     sig_as_inb;
  logic [1:0]           sig_as_op;
  logic                 sig_as_in_valid;
  logic                 sig_as_in_ready;
  logic [WIDTH:0]       sig_as_out;
  logic                 sig_as_zero;
  logic                 sig_as_out_valid;
  logic                 sig_as_out_ready;
  logic [CNT_WIDTH-1:0] sig_as_count;
  modport master (
    output sig_as_ina, sig_as_inb, sig_as_op, sig_as_in_valid, sig_as_out_ready,
    input  sig_as_in_ready, sig_as_out, sig_as_zero, sig_as_out_valid, sig_as_count
  );
  modport slave (
    input  sig_as_ina, sig_as_inb, sig_as_op, sig_as_in_valid, sig_as_out_ready,
    output sig_as_in_ready, sig_as_out, sig_as_zero, sig_as_out_valid, sig_as_count
  );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage valid/ready add/sub/absdiff/satsub unit with zero flag and delivery counter.
module addsub_pipe #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input logic          sig_as_clock,
  input logic          sig_as_rst,
  addsub_pipe_if.slave bus
);
  logic                 s1_valid, s2_valid, s2_zero, adv2, in_ready, lt, zero;
  logic [WIDTH-1:0]     s1_a, s1_b;
  logic [1:0]           s1_op;
  logic [WIDTH:0]       s2_out, sum, diff, res;
  logic [CNT_WIDTH-1:0] count;
  assign adv2     = !s2_valid || bus.sig_as_out_ready;
  // in_ready follows out_ready combinationally so a full pipe refills without a bubble
  assign in_ready = !s1_valid || adv2;
  always_comb begin
    sum  = {1'b0, s1_a} + {1'b0, s1_b};
    diff = {1'b0, s1_a} - {1'b0, s1_b};
    lt   = diff[WIDTH];
    res  = s1_op == 2'd0 ? sum :
           s1_op == 2'd1 ? diff :
           s1_op == 2'd2 ? {lt, lt ? s1_b - s1_a : diff[WIDTH-1:0]} :
           lt ? {1'b1, {WIDTH{1'b0}}} : diff;
    zero = res[WIDTH-1:0] == '0;
  end
  always_ff @(posedge sig_as_clock or posedge sig_as_rst)
    if (sig_as_rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s2_valid <= 1'b0;
      s2_out   <= '0;
      s2_zero  <= 1'b0;
      count    <= '0;
    end else begin
      if (adv2) begin
        s2_valid <= s1_valid;
        s2_out   <= res;
        s2_zero  <= zero;
      end
      if (in_ready) begin
        s1_valid <= bus.sig_as_in_valid;
        s1_a     <= bus.sig_as_ina;
        s1_b     <= bus.sig_as_inb;
        s1_op    <= bus.sig_as_op;
      end
      if (s2_valid && bus.sig_as_out_ready) count <= count + CNT_WIDTH'(1);
    end
  assign bus.sig_as_in_ready  = in_ready;
  assign bus.sig_as_out       = s2_out;
  assign bus.sig_as_zero      = s2_zero;
  assign bus.sig_as_out_valid = s2_valid;
  assign bus.sig_as_count     = count;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed + random checks of addsub_pipe against a queue-based mode-equation model.
module tb_addsub_pipe;
  localparam int W  = 16;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  addsub_pipe_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus_i ();
  addsub_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (.sig_as_clock(clk), .sig_as_rst(rst), .bus(bus_i));
  typedef struct {logic [W:0] r; int t;} ent_t;
  typedef struct {logic [W:0] r; logic z; int t;} dl_t;
  ent_t q[$];
  dl_t  dlog[$];
  int   alog[$];
  int   cyc = 0, mcnt = 0, n_vec = 0, n_err = 0;
  logic acc, dummy;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    end
  endfunction

  function automatic logic [W:0] model(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
    longint ai = a, bi = b;
    case (op)
      2'd0:    return (W+1)'(ai + bi);
      2'd1:    return (W+1)'(ai - bi);
      2'd2:    return ai < bi ? {1'b1, W'(bi - ai)} : {1'b0, W'(ai - bi)};
      default: return ai < bi ? {1'b1, {W{1'b0}}} : (W+1)'(ai - bi);
    endcase
  endfunction

  // scoreboard: accepted operands queue up, delivered results leave from the front
  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (bus_i.sig_as_out_valid && bus_i.sig_as_out_ready) begin
        dlog.push_back('{bus_i.sig_as_out, bus_i.sig_as_zero, cyc});
        if (q.size() > 0) void'(q.pop_front());
        mcnt++;
      end
      if (bus_i.sig_as_in_valid && bus_i.sig_as_in_ready) begin
        q.push_back('{model(bus_i.sig_as_ina, bus_i.sig_as_inb, bus_i.sig_as_op), cyc});
        alog.push_back(cyc);
      end
      cyc++;
    end

  always @(negedge clk) begin
    logic ov;
    ov = q.size() > 0 ? cyc >= q[0].t + 2 : 1'b0;
    chk("in_ready", bus_i.sig_as_in_ready, q.size() < 2 || bus_i.sig_as_out_ready);
    chk("out_valid", bus_i.sig_as_out_valid, ov);
    if (ov && bus_i.sig_as_out_valid) begin
      chk("out", bus_i.sig_as_out, q[0].r);
      chk("zero", bus_i.sig_as_zero, q[0].r[W-1:0] == 0);
    end
    chk("count", bus_i.sig_as_count, mcnt % (1 << CW));
    if (rst) begin
      chk("rst_out", bus_i.sig_as_out, 0);
      chk("rst_zero", bus_i.sig_as_zero, 0);
    end
  end

  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, input logic ordy, output logic ac);
    bus_i.sig_as_in_valid  = v;
    bus_i.sig_as_ina       = a;
    bus_i.sig_as_inb       = b;
    bus_i.sig_as_op        = op;
    bus_i.sig_as_out_ready = ordy;
    @(negedge clk);
    ac = v & bus_i.sig_as_in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    logic ac = 1'b0;
    for (int i = 0; i < 20 && !ac; i++) step(1'b1, a, b, op, 1'b1, ac);
    chk("send_accept", ac, 1);
  endtask

  task automatic drain();
    logic ac;
    for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, '0, '0, 2'd0, 1'b1, ac);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    bus_i.sig_as_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic lit(input int i, input logic [W:0] r, input logic z);
    chk("lit_out", i < dlog.size() ? dlog[i].r : 'x, r);
    chk("lit_zero", i < dlog.size() ? dlog[i].z : 1'bx, z);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [W-1:0] ma[5] = '{16'hFFFF, 16'd5, 16'd5, 16'd5, 16'd9};
    logic [W-1:0] mb[5] = '{16'h0001, 16'd7, 16'd7, 16'd7, 16'd4};
    logic [1:0]   mo[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [W:0]   mr[5] = '{17'h10000, 17'h1FFFE, 17'h10002, 17'h10000, 17'h00005};
    logic         mz[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] ba[4] = '{16'd1, 16'd10, 16'd100, 16'd5};
    logic [W-1:0] bb[4] = '{16'd2, 16'd3, 16'd1, 16'd5};
    logic [1:0]   bo[4] = '{2'd0, 2'd1, 2'd0, 2'd0};
    logic [W:0]   br[4] = '{17'd3, 17'd7, 17'd101, 17'd10};
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    logic         pend;
    int           ptr;
    bus_i.sig_as_in_valid = 1'b0; bus_i.sig_as_ina = '0; bus_i.sig_as_inb = '0;
    bus_i.sig_as_op = '0; bus_i.sig_as_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", bus_i.sig_as_in_ready, 1);
    chk("rst_out_valid", bus_i.sig_as_out_valid, 0);
    dlog.delete(); alog.delete();
    for (int i = 0; i < 5; i++) send(ma[i], mb[i], mo[i]);
    drain();
    chk("mode_n", dlog.size(), 5);
    chk("mode_latency", dlog.size() > 0 ? dlog[0].t - alog[0] : -1, 2);
    for (int i = 0; i < 5; i++) begin
      lit(i, mr[i], mz[i]);
      chk("mode_consec", i < dlog.size() ? dlog[i].t - dlog[0].t : -1, i);
    end
    dlog.delete();
    send(16'h0000, 16'h0000, 2'd1);
    send(16'hFFFF, 16'h0000, 2'd2);
    send(16'h0000, 16'h0000, 2'd0);
    drain();
    lit(0, 17'h00000, 1'b1);
    lit(1, 17'h0FFFF, 1'b0);
    lit(2, 17'h00000, 1'b1);
    dlog.delete();
    step(1'b1, 16'd1, 16'd1, 2'd0, 1'b0, dummy);
    step(1'b1, 16'd2, 16'd2, 2'd0, 1'b0, dummy);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus_i.sig_as_out_valid, 0);
    chk("midrst_out", bus_i.sig_as_out, 0);
    chk("midrst_count", bus_i.sig_as_count, 0);
    bus_i.sig_as_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_in_ready", bus_i.sig_as_in_ready, 1);
    repeat (5) step(1'b0, '0, '0, 2'd0, 1'b1, dummy);
    chk("midrst_no_ghost", dlog.size(), 0);
    ptr = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, ba[ptr], bb[ptr], bo[ptr], 1'b0, acc);
      if (acc) ptr++;
    end
    chk("bp_accepted", ptr, 2);
    chk("bp_in_ready_low", bus_i.sig_as_in_ready, 0);
    chk("bp_out_hold", bus_i.sig_as_out, 17'd3);
    step(1'b1, ba[2], bb[2], bo[2], 1'b1, acc);
    chk("bp_pulse_accept", acc, 1);
    step(1'b1, ba[3], bb[3], bo[3], 1'b0, acc);
    chk("bp_full_again", acc, 0);
    send(ba[3], bb[3], bo[3]);
    drain();
    chk("bp_n", dlog.size(), 4);
    for (int i = 0; i < 4; i++) chk("bp_order", i < dlog.size() ? dlog[i].r : 'x, br[i]);
    do_reset();
    for (int i = 0; i < 15; i++) send(W'(i), 16'd1, 2'd0);
    drain();
    chk("wrap_15", bus_i.sig_as_count, 15);
    send(16'd1, 16'd1, 2'd0);
    drain();
    chk("wrap_16", bus_i.sig_as_count, 0);
    send(16'd2, 16'd1, 2'd0);
    drain();
    chk("wrap_17", bus_i.sig_as_count, 1);
    pend = 1'b0; ra = '0; rb = '0; rop = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!pend) begin
        pend = $urandom_range(0, 3) != 0;
        ra = pick(); rb = pick(); rop = 2'($urandom_range(0, 3));
      end
      step(pend, ra, rb, rop, $urandom_range(0, 2) != 0, acc);
      if (acc) pend = 1'b0;
    end
    bus_i.sig_as_in_valid = 1'b0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised two-stage pipelined add/subtract unit with a valid/ready handshake on both sides. It supports four arithmetic modes and reports a zero flag. It also keeps a count of delivered results. It replaces the single-cycle enable-driven subtractor in the arithmetic datapath and tolerates downstream backpressure without losing or duplicating operands.

## Interface
- WIDTH, 16, operand width in bits (≥2)
- CNT_WIDTH, 8, width of delivered-result counter (≥1)

- sig_as_clock  input  1  single clock, all state updates on rising edge
- sig_as_rst  input  1  asynchronous, active-high reset
- sig_as_ina  input  WIDTH  operand A, unsigned
- sig_as_inb  input  WIDTH  operand B, unsigned
- sig_as_op  input  2  mode: 00 add, 01 sub, 10 absdiff, 11 satsub
- sig_as_in_valid  input  1  operands/op valid this cycle
- sig_as_in_ready  output  1  unit accepts operands this cycle
- sig_as_out  output  WIDTH+1  result; MSB is carry/borrow/flag per mode
- sig_as_zero  output  1  sig_as_out[WIDTH-1:0] == 0
- sig_as_out_valid  output  1  sig_as_out/sig_as_zero valid
- sig_as_out_ready  input  1  consumer takes result this cycle
- sig_as_count  output  CNT_WIDTH  number of results delivered, wraps

## Operation
- Arithmetic is done on zero-extended operands a = {0,A} and b = {0,B}, modulo 2^(WIDTH+1).
- add: out = a + b. MSB = carry.
- sub: out = a − b. MSB = 1 iff A < B (borrow). The low bits are the two's-complement difference.
- absdiff: out[WIDTH-1:0] = |A − B|. MSB = 1 iff A < B (operands were swapped).
- satsub: if A ≥ B, out = {0, A−B}. Otherwise out = {1, 0…0} (clamped; MSB flags the clamp).
- zero = (out[WIDTH-1:0] == 0). It is computed on the same stage as out, so it is never stale.
- Stage 1 (S1) registers A, B and op. Stage 2 (S2) registers the computed out and zero. Each stage has its own valid bit.
- Handshake transfer: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- adv2 = !s2_valid || out_ready.
- in_ready = !s1_valid || adv2. This is a combinational path from out_ready; it is intentional and documented.
- On adv2, S2 loads the result from S1 and s2_valid ← s1_valid.
- When in_ready is high, S1 loads the inputs and s1_valid ← in_valid.
- When a stage is not advancing, its data and valid hold.
- Inputs presented while in_ready = 0 are ignored. The source must hold them.
- Once out_valid = 1, out and zero stay stable until the output transfer.
- count increments by 1 on each output transfer and wraps from 2^CNT_WIDTH−1 to 0.
- Reset, asserted at any time including mid-operation:
  - s1_valid = s2_valid = 0 and in-flight operands are discarded.
  - out = 0, zero = 0, out_valid = 0, count = 0.
  - in_ready = 1 while reset is deasserted and the pipeline is empty.
- No $display or other simulation side effects in the RTL.

## Timing
- Latency: 2 cycles from the input-transfer edge to out_valid, with no stall.
- Throughput: 1 result per cycle while out_ready is held high.
- Backpressure:
  - With out_ready low, the pipe fills with at most 2 results.
  - After that, in_ready drops in the same cycle.
  - When out_ready rises, in_ready rises combinationally in that cycle, so no bubble is inserted.
- Simultaneous input and output transfer when full: both occur. S2 takes S1 and S1 takes the new operands. The count still increments.
- Reset deassertion: the first input can be accepted on the first rising edge after reset goes low.
- Reset is not synchronised inside the block. Deassertion must meet recovery/removal at the system level.

## Test plan
- Reset: drive rst=1 mid-stream with 2 results in flight. Required: out_valid=0, out=0, count=0, in_ready=1 after release, and neither in-flight result ever appears.
- Modes, WIDTH=16, streamed back-to-back with out_ready=1:
  - add 0xFFFF+0x0001 → out=0x10000, zero=1
  - sub 5−7 → out=0x1FFFE
  - absdiff 5,7 → out=0x10002
  - satsub 5−7 → out=0x10000, zero=1
  - satsub 9−4 → out=0x00005
  - Results appear on 5 consecutive cycles starting 2 cycles after the first accept.
- Backpressure:
  - Hold out_ready=0 while feeding 4 vectors. Required: exactly 2 accepted, in_ready=0, out held stable.
  - Then pulse out_ready=1 for 1 cycle. Required: in_ready goes high the same cycle, the 3rd vector is accepted, and the order is preserved.
- Random: 10,000 random op/operand/valid/out_ready cycles against a scoreboard. Required: no loss, duplication or reordering, and every result matches the mode equations.
- Counter wrap: with CNT_WIDTH=4, deliver 17 results. Required: count=1, and it wraps from 15 to 0 on the 16th transfer.
- Edge operands: sub 0−0 → out=0, zero=1; absdiff 0xFFFF,0 → 0x0FFFF; add 0+0 → 0, zero=1.
